// File: rtl/axis_fifo.sv
// First-word-fall-through valid/ready stream FIFO with an optional occupancy output.
// The AXIS_FIFO_COUNT_EN macro adds the ocount port (occupancy 0..DEPTH).
module axis_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      idata,
   input  logic                  ivalid,
   output logic                  iready,
   output logic [WIDTH-1:0]      odata,
   output logic                  ovalid,
   input  logic                  oready
`ifdef AXIS_FIFO_COUNT_EN
   ,
   output logic [DEPTH_LOG2:0]   ocount
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wptr_reg;
   logic [PW-1:0] rptr_reg;
   logic [PW-1:0] wptr_next;
   logic [PW-1:0] rptr_next;
   logic          iready_reg;
   logic          full_next;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty  = (wptr_reg == rptr_reg);
   assign ovalid = !empty;
   assign iready = iready_reg;
   assign push   = ivalid & iready_reg;
   assign pop    = ovalid & oready;

   assign wptr_next = wptr_reg + {{(PW-1){1'b0}}, push};
   assign rptr_next = rptr_reg + {{(PW-1){1'b0}}, pop};

   // Full when the index bits match but the wrap flags differ.
   assign full_next = (wptr_next[DEPTH_LOG2-1:0] == rptr_next[DEPTH_LOG2-1:0]) &&
                      (wptr_next[DEPTH_LOG2] != rptr_next[DEPTH_LOG2]);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wptr_reg   <= '0;
         rptr_reg   <= '0;
         iready_reg <= 1'b0;
      end else begin
         wptr_reg   <= wptr_next;
         rptr_reg   <= rptr_next;
         iready_reg <= !full_next;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr_reg[DEPTH_LOG2-1:0]] <= idata;
      end
   end

   // Head word falls through without a read request.
   assign odata = mem[rptr_reg[DEPTH_LOG2-1:0]];

`ifdef AXIS_FIFO_COUNT_EN
   assign ocount = wptr_reg - rptr_reg;
`endif

endmodule
